// File: rtl/regfile_param_if.sv
`timescale 1ns/1ps
// regfile_param_if: register-file access bundle (clear request/ready, write port, packed read ports).
// Read ports are packed; port p uses raddr[p*AW +: AW] and rdata[p*XLEN +: XLEN].
interface regfile_param_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NREAD = 2
);
  localparam int AW = $clog2(NREGS);

  logic                    clr_req;
  logic                    ready;
  logic                    we;
  logic [AW-1:0]           waddr;
  logic [XLEN-1:0]         wdata;
  logic [NREAD*AW-1:0]     raddr;
  logic [NREAD*XLEN-1:0]   rdata;

  modport master (output clr_req, we, waddr, wdata, raddr, input ready, rdata);
  modport slave  (input clr_req, we, waddr, wdata, raddr, output ready, rdata);
endinterface

// File: rtl/regfile_param.sv
`timescale 1ns/1ps
// regfile_param: x0-hardwired register file with sequential clear sweep; REGFILE_BYPASS_EN adds write-to-read forwarding.
// Reads combinational, writes land one edge later; no backpressure, writes offered while ready=0 are dropped.
module regfile_param #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NREAD = 2
) (
  input  logic           clock,
  input  logic           reset_n,
  regfile_param_if.slave rf
);
  localparam int AW = $clog2(NREGS);
  localparam logic [AW-1:0] FIRST_IDX = AW'(1);
  localparam logic [AW-1:0] LAST_IDX  = AW'(NREGS - 1);

  typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   cidx, cidx_nxt;
  logic [XLEN-1:0] mem [NREGS];
  logic            wr_ok;

  function automatic logic idx_valid(input logic [AW-1:0] idx);
    return (idx != '0) && (32'(idx) < NREGS);
  endfunction

  assign rf.ready = (state == READY);
  // A clear request in the same cycle wins over the write
  assign wr_ok = (state == READY) && !rf.clr_req && rf.we && idx_valid(rf.waddr);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= CLEAR;
      cidx  <= FIRST_IDX;
    end else begin
      state <= state_nxt;
      cidx  <= cidx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cidx_nxt  = cidx;
    case (state)
      CLEAR: begin
        if (cidx == LAST_IDX) begin
          state_nxt = READY;
          cidx_nxt  = FIRST_IDX;
        end else begin
          cidx_nxt = cidx + AW'(1);
        end
      end
      READY: begin
        if (rf.clr_req) begin
          state_nxt = CLEAR;
          cidx_nxt  = FIRST_IDX;
        end
      end
      default: begin
        state_nxt = CLEAR;
        cidx_nxt  = FIRST_IDX;
      end
    endcase
  end

  // Storage carries no reset; contents are masked by ready until the sweep finishes
  always_ff @(posedge clock) begin
    if (state == CLEAR) begin
      mem[cidx] <= '0;
    end else if (wr_ok) begin
      mem[rf.waddr] <= rf.wdata;
    end
  end

  for (genvar p = 0; p < NREAD; p++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rd;

    assign ra = rf.raddr[p*AW +: AW];

    always_comb begin
      rd = '0;
      if ((state == READY) && idx_valid(ra)) begin
`ifdef REGFILE_BYPASS_EN
        if (wr_ok && (rf.waddr == ra)) begin
          rd = rf.wdata;
        end else begin
          rd = mem[ra];
        end
`else
        rd = mem[ra];
`endif
      end
    end

    assign rf.rdata[p*XLEN +: XLEN] = rd;
  end
endmodule

// File: doc/regfile_param.md
# regfile_param

Parametrised multi-read-port integer register file for the pipelined RISC-V core. It replaces fixed 32x32 storage with configurable width, depth and read-port count. Register 0 is hardwired to zero, and a sequential clear engine zeroes the array after reset or on request. An optional write-to-read bypass removes the decode-stage/write-back hazard.

## Interface
- XLEN, 32: data width in bits; 8..64.
- NREGS, 32: number of architectural registers, entry 0 included; 2..256, need not be a power of two.
- NREAD, 2: number of read ports; 1..4.
- AW, $clog2(NREGS): address width, derived, not overridden.
- clock  in  1  single clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- clr_req  in  1  single-cycle request to re-zero the array; honoured only when ready=1.
- ready  out  1  registered; 1 = array valid and writable.
- we  in  1  write enable.
- waddr  in  AW  write register index.
- wdata  in  XLEN  write data.
- raddr  in  NREAD*AW  read indices; port p occupies bits [p*AW +: AW].
- rdata  out  NREAD*XLEN  read data; port p occupies bits [p*XLEN +: XLEN]; combinational.

## Operation
- Two-state FSM: CLEAR and READY. It has a clear-index counter cidx of width AW.
- Reset (reset_n=0), asynchronous:
  - state=CLEAR, cidx=1, ready=0.
  - The array itself is not reset.
- CLEAR:
  - Each rising edge writes 0 to entry cidx and increments cidx.
  - On the edge that clears entry NREGS-1: state becomes READY, ready becomes 1, and cidx returns to 1.
  - we is ignored.
  - clr_req is ignored; it does not restart the sweep.
- READY:
  - If clr_req=1 on an edge: state becomes CLEAR, ready becomes 0, cidx=1. Any write in that same cycle is dropped.
  - Otherwise, if we=1, waddr!=0 and waddr<NREGS: entry waddr takes wdata.
  - Writes to index 0 or to an index ≥NREGS are discarded silently.
- Read port p, evaluated in priority order:
  - 0 if ready=0.
  - Else 0 if raddr_p==0 or raddr_p≥NREGS.
  - Else the bypass value, when bypass is compiled in (see Configuration).
  - Else the array entry.
- All read ports are independent. Any number of ports may address the same index.
- Entry 0 is never physically written and always reads 0.

## Timing
- Read latency: zero cycles. rdata is combinational from raddr, array contents, ready and, when bypass is enabled, we/waddr/wdata.
- Write latency: one edge. Without bypass, a value written on edge N is visible on rdata after edge N.
- Clear duration: exactly NREGS-1 rising edges after reset_n deasserts, or after the edge that samples clr_req.
  - ready rises immediately after the final clear edge.
  - For NREGS=32: ready=1 after the 31st edge.
- NREGS=2: clear completes in one edge.
- Reset asserted mid-clear: the sweep restarts at cidx=1 after release. The partially cleared array is irrelevant because reads return 0 while ready=0.
- ready is driven directly from the state flop, so it carries no combinational path from inputs.
- Requirement on the pipeline: hold off issue while ready=0. Writes offered in that window are lost by design.

## Configuration
- Macro: REGFILE_BYPASS_EN.
- Defined: in READY, if we=1, waddr==raddr_p, waddr!=0, waddr<NREGS and clr_req=0, then rdata_p=wdata in the same cycle, ahead of the array write.
- Undefined: no forwarding path. rdata_p reflects only the array, so a same-cycle write shows the old value until after the edge.
- The macro has no effect on FSM, clear or port behaviour.

## Test plan
- Reset then clear, NREGS=32: hold reset_n=0 for 3 cycles, then release. ready=0 for 30 edges and 1 after edge 31. All 31 nonzero entries then read 0 on both ports.
- Write/read, bypass undefined: we=1, waddr=5, wdata=0xDEADBEEF. Both ports read 0 in the same cycle and 0xDEADBEEF after the edge. Writing 0x12345678 to index 0 leaves reads of index 0 at 0.
- Bypass defined: we=1, waddr=7, wdata=0xA5A5A5A5, raddr0=7, raddr1=8. In the same cycle port0=0xA5A5A5A5 and port1=old entry 8. The same stimulus with clr_req=1 gives port0 equal to the old entry 7, and the write is dropped.
- Runtime clear: fill entries 1..31 with index*0x11. Pulse clr_req for one cycle. ready=0 for exactly 31 edges, and reads return 0 throughout. After ready=1 every entry reads 0. A write with we=1 during CLEAR to index 3 is not retained.
- Reset mid-clear: assert reset_n=0 asynchronously at edge 10 of a clear, then release. ready rises only after 31 further edges.
- Parameter sweep: XLEN=64, NREGS=20, NREAD=3. Clear takes 19 edges. A write to index 25 is discarded, and a read of index 25 returns 0. All three ports read distinct entries 1, 10 and 19 correctly.
